// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined carry-chunk adder.
// The stage record is sized for the widest supported adder; narrower
// instances simply leave the upper bits at zero.
package adder_pkg;

  localparam int ADDER_DEF_WIDTH  = 16;
  localparam int ADDER_DEF_STAGES = 4;
  localparam int ADDER_MAX_WIDTH  = 64;

  // One pipeline register: completed low sum chunks plus the operand
  // chunks that still have to be added by later stages.
  typedef struct packed {
    logic                       valid;
    logic                       carry;
    logic [ADDER_MAX_WIDTH-1:0] sum;
    logic [ADDER_MAX_WIDTH-1:0] opA;
    logic [ADDER_MAX_WIDTH-1:0] opB;
  } stage_t;

  // Mask selecting operand bits [consumed, width) that are still pending.
  function automatic logic [ADDER_MAX_WIDTH-1:0] pendingMask(input int width,
                                                             input int consumed);
    logic [ADDER_MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < ADDER_MAX_WIDTH; i++) begin
      if (i >= consumed && i < width) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry adder row of CHUNK bits, one per pipeline stage.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic w_c;

  // Ripple the carry from bit 0 upward, producing each sum bit on the way.
  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder: WIDTH-bit add split into STAGES chunks of WIDTH/STAGES bits,
// one chunk per register stage, with valid/ready flow control and bubble
// collapsing. WIDTH must be a multiple of STAGES and at most ADDER_MAX_WIDTH.
// Optional feature: define PIPELINED_ADDER_OVF_EN to add the signed overflow
// output 'ovf', which travels with the sum.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_DEF_WIDTH,
  parameter int STAGES = ADDER_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  stage_t                     r_stage    [STAGES];
  logic [STAGES-1:0]          w_adv;
  logic [ADDER_MAX_WIDTH-1:0] w_srcA     [STAGES];
  logic [ADDER_MAX_WIDTH-1:0] w_srcB     [STAGES];
  logic [ADDER_MAX_WIDTH-1:0] w_srcSum   [STAGES];
  logic                       w_srcCarry [STAGES];
  logic                       w_srcValid [STAGES];
  logic [CHUNK-1:0]           w_chunkSum [STAGES];
  logic                       w_chunkCout[STAGES];
  logic [STAGES-1:0]          w_unusedBits;

  // A stage may load when it is empty or its contents move on this cycle;
  // the last stage moves on when downstream takes the result.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !r_stage[STAGES-1].valid || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !r_stage[k].valid || w_adv[k+1];
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_stage[STAGES-1].valid;
  assign sum       = r_stage[STAGES-1].sum[WIDTH-1:0];
  assign cout      = r_stage[STAGES-1].carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [ADDER_MAX_WIDTH-1:0] PENDING = pendingMask(WIDTH, (k + 1) * CHUNK);

    logic [ADDER_MAX_WIDTH-1:0] w_nextSum;

    if (k == 0) begin : g_first
      assign w_srcA[k]     = ADDER_MAX_WIDTH'(a);
      assign w_srcB[k]     = ADDER_MAX_WIDTH'(b);
      assign w_srcSum[k]   = '0;
      assign w_srcCarry[k] = cin;
      assign w_srcValid[k] = in_valid;
    end else begin : g_later
      assign w_srcA[k]     = r_stage[k-1].opA;
      assign w_srcB[k]     = r_stage[k-1].opB;
      assign w_srcSum[k]   = r_stage[k-1].sum;
      assign w_srcCarry[k] = r_stage[k-1].carry;
      assign w_srcValid[k] = r_stage[k-1].valid;
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a   (w_srcA[k][k*CHUNK +: CHUNK]),
      .i_b   (w_srcB[k][k*CHUNK +: CHUNK]),
      .i_cin (w_srcCarry[k]),
      .o_sum (w_chunkSum[k]),
      .o_cout(w_chunkCout[k])
    );

    // Merge this stage's freshly computed chunk into the running sum.
    always_comb begin
      w_nextSum = w_srcSum[k];
      w_nextSum[k*CHUNK +: CHUNK] = w_chunkSum[k];
    end

    // Stage register: the valid bit follows the upstream on every advance;
    // data is only loaded for real transactions so outputs stay quiet on bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_stage[k] <= '0;
      end else if (w_adv[k]) begin
        r_stage[k].valid <= w_srcValid[k];
        if (w_srcValid[k]) begin
          r_stage[k].carry <= w_chunkCout[k];
          r_stage[k].sum   <= w_nextSum;
          r_stage[k].opA   <= w_srcA[k] & PENDING;
          r_stage[k].opB   <= w_srcB[k] & PENDING;
        end
      end
    end

    assign w_unusedBits[k] = ^r_stage[k];
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow = carry into the MSB xor carry out of it, computed as the
  // result enters the last stage so it stays aligned with sum and cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv[STAGES-1] && w_srcValid[STAGES-1]) begin
      r_ovf <= w_srcA[STAGES-1][WIDTH-1] ^ w_srcB[STAGES-1][WIDTH-1]
             ^ w_chunkSum[STAGES-1][CHUNK-1] ^ w_chunkCout[STAGES-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder: a 16-bit/4-stage
// instance for latency, streaming, stall and reset behaviour, plus a
// 4-bit/2-stage instance swept over every operand/carry combination.
// Overflow checks are compiled in when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic        inValid, inReady, cin, outValid, outReady, cout;
  logic [15:0] a, b, sum;
  logic        sInValid, sInReady, sCin, sOutValid, sOutReady, sCout;
  logic [3:0]  sA, sB, sSum;
`ifdef PIPELINED_ADDER_OVF_EN
  logic        ovf, sOvf;
`endif

  int checkCount = 0;
  int failCount  = 0;

  logic [16:0] bigQ[$];
  logic [5:0]  smallQ[$];

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_big (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .cin(cin),
    .out_valid(outValid), .out_ready(outReady),
    .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(4), .STAGES(2)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(sInValid), .in_ready(sInReady),
    .a(sA), .b(sB), .cin(sCin),
    .out_valid(sOutValid), .out_ready(sOutReady),
    .sum(sSum), .cout(sCout)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(sOvf)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                               input logic c);
    inValid = v;
    a       = av;
    b       = bv;
    cin     = c;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (n) tick();
  endtask

  logic [15:0] btA  [3] = '{16'h0001, 16'h0003, 16'h8000};
  logic [15:0] btB  [3] = '{16'h0002, 16'h0004, 16'h8000};
  logic [16:0] btExp[3] = '{17'h00003, 17'h00007, 17'h10000};

  logic [15:0] stA  [6] = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h8000, 16'h0F0F, 16'hABCD};
  logic [15:0] stB  [6] = '{16'h1111, 16'hFFFF, 16'h0001, 16'h7FFF, 16'hF0F0, 16'h1234};
  logic        stC  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [16:0] stExp[6] = '{17'h02345, 17'h1FFFF, 17'h00100, 17'h10000, 17'h0FFFF, 17'h0BE02};

  initial begin
    int acc;
    int got;
    logic [4:0] smallSum;
    logic       smallOvf;

    // Reset with junk on the inputs: nothing may be captured.
    rst       = 1'b1;
    outReady  = 1'b1;
    applyStimulus(1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
    sInValid  = 1'b1;
    sA        = 4'hF;
    sB        = 4'hF;
    sCin      = 1'b1;
    sOutReady = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    sInValid = 1'b0;
    checkOutput("reset_outValid", outValid, 0);
    checkOutput("reset_sumCout", {cout, sum}, 0);
    checkOutput("reset_inReady", inReady, 1);
    checkOutput("reset_smallValid", sOutValid, 0);
`ifdef PIPELINED_ADDER_OVF_EN
    checkOutput("reset_ovf", ovf, 0);
`endif

    // Single add with full carry propagation through every chunk.
    applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    checkOutput("lat_inReady", inReady, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      if (c < 4) begin
        checkOutput("lat_earlyValid", outValid, 0);
      end else begin
        checkOutput("lat_outValid", outValid, 1);
        checkOutput("lat_sumCout", {cout, sum}, 17'h10000);
      end
    end
    idle(2);

    // Three back-to-back adds, results on consecutive cycles 4..6.
    for (int c = 0; c <= 7; c++) begin
      if (c >= 4 && c <= 6) begin
        checkOutput("b2b_valid", outValid, 1);
        checkOutput("b2b_result", {cout, sum}, btExp[c-4]);
      end else if (c == 3 || c == 7) begin
        checkOutput("b2b_idle", outValid, 0);
      end
      if (c < 3) applyStimulus(1'b1, btA[c], btB[c], 1'b0);
      else       applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle(2);

    // Stream six adds into a stalled output, then release it.
    outReady = 1'b0;
    acc = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (acc < 6) applyStimulus(1'b1, stA[acc], stB[acc], stC[acc]);
      else         applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      if (c == 10) outReady = 1'b1;
      #1;
      if (c == 6) checkOutput("stall_held6", {cout, sum}, stExp[0]);
      if (c == 8) begin
        checkOutput("stall_inReady", inReady, 0);
        checkOutput("stall_accepted", acc, 4);
        checkOutput("stall_valid", outValid, 1);
        checkOutput("stall_held8", {cout, sum}, stExp[0]);
      end
      if (c == 10) checkOutput("stall_releaseReady", inReady, 1);
      if (inValid && inReady) begin
        bigQ.push_back(stExp[acc]);
        acc++;
      end
      if (outValid && outReady) begin
        checkOutput("stall_pending", bigQ.size() != 0, 1);
        if (bigQ.size() != 0) checkOutput("stall_order", {cout, sum}, bigQ.pop_front());
        got++;
      end
      tick();
    end
    checkOutput("stall_outCount", got, 6);
    checkOutput("stall_inCount", acc, 6);
    idle(2);

    // Reset while three adds are in flight; nothing may emerge afterwards.
    applyStimulus(1'b1, 16'h0011, 16'h0022, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0101, 16'h0202, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h1000, 16'h2000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    checkOutput("rstmid_outValid", outValid, 0);
    checkOutput("rstmid_inReady", inReady, 1);
    checkOutput("rstmid_sumCout", {cout, sum}, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput("rstmid_noStale", outValid, 0);
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow travels with its sum.
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    checkOutput("ovf_sum1", {cout, sum}, 17'h08000);
    checkOutput("ovf_set", ovf, 1);
    tick();
    checkOutput("ovf_sum2", {cout, sum}, 17'h00002);
    checkOutput("ovf_clear", ovf, 0);
    idle(2);
`endif

    // Exhaustive 4-bit sweep with random downstream back-pressure.
    acc = 0;
    got = 0;
    for (int c = 0; c < 6000 && got < 512; c++) begin
      sInValid  = (acc < 512);
      sCin      = acc[8];
      sA        = acc[7:4];
      sB        = acc[3:0];
      sOutReady = 1'($urandom_range(0, 1));
      #1;
      if (sInValid && sInReady) begin
        smallSum = {1'b0, sA} + {1'b0, sB} + {4'b0, sCin};
        smallOvf = (sA[3] == sB[3]) && (smallSum[3] != sA[3]);
        smallQ.push_back({smallOvf, smallSum});
        acc++;
      end
      if (sOutValid && sOutReady) begin
        checkOutput("small_pending", smallQ.size() != 0, 1);
        if (smallQ.size() != 0) begin
`ifdef PIPELINED_ADDER_OVF_EN
          checkOutput("small_result", {sOvf, sCout, sSum}, smallQ.pop_front());
`else
          checkOutput("small_result", {sCout, sSum}, 5'(smallQ.pop_front()));
`endif
        end
        got++;
      end
      tick();
    end
    sInValid  = 1'b0;
    sOutReady = 1'b1;
    checkOutput("small_outCount", got, 512);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
